// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard/stall bundle between the pipeline datapath and the hazard controller.
// master: the datapath side (raises hazards, consumes stall/flush).
// slave:  the controller side.
interface pipe_hazard_ctrl_if;
  logic        i_ld_use;
  logic        i_br_taken;
  logic        i_div_start;
  logic        i_div_ready;
  logic        i_inst_stall;
  logic        i_data_stall;
  logic        i_exc;
  logic        o_stall_f;
  logic        o_stall_d;
  logic        o_stall_e;
  logic        o_stall_m;
  logic        o_stall_w;
  logic        o_flush_d;
  logic        o_flush_e;
  logic        o_flush_m;
  logic        o_flush_w;
  logic        o_exc_redirect;
  logic        o_div_timeout;
  logic [1:0]  o_state;
  logic [31:0] o_stall_cnt;

  modport master (
    output i_ld_use, i_br_taken, i_div_start, i_div_ready,
           i_inst_stall, i_data_stall, i_exc,
    input  o_stall_f, o_stall_d, o_stall_e, o_stall_m, o_stall_w,
           o_flush_d, o_flush_e, o_flush_m, o_flush_w,
           o_exc_redirect, o_div_timeout, o_state, o_stall_cnt
  );

  modport slave (
    input  i_ld_use, i_br_taken, i_div_start, i_div_ready,
           i_inst_stall, i_data_stall, i_exc,
    output o_stall_f, o_stall_d, o_stall_e, o_stall_m, o_stall_w,
           o_flush_d, o_flush_e, o_flush_m, o_flush_w,
           o_exc_redirect, o_div_timeout, o_state, o_stall_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage F/D/E/M/W pipeline.
// Optional stall-cycle performance counter: define PIPE_HAZARD_CTRL_PERF_EN.
// Without it o_stall_cnt reads 0 and no counter is built.
//
// state | meaning
// RUN   | normal issue, hazards decoded with fixed priority
// DIV   | multi-cycle divide in E, watchdog counting
// MEMW  | inst/data SRAM wait, whole pipe frozen
// EXCP  | exception seen while data SRAM busy, redirect pending
module pipe_hazard_ctrl #(
  parameter int DIV_MAX_CYC = 36,
  parameter int CNT_W       = 6
) (
  input  logic               clk,
  input  logic               rst,
  pipe_hazard_ctrl_if.slave  hz
);

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    DIV  = 2'd1,
    MEMW = 2'd2,
    EXCP = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_MAX_CYC - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  logic sram_stall;
  logic run_dec;
  logic st_f, st_d, st_e, st_m, st_w;
  logic fl_d, fl_e, fl_m, fl_w;
  logic redirect, timeout;

  assign sram_stall = hz.i_inst_stall | hz.i_data_stall;

  // State and divide watchdog registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state and raw stall/flush decode; MEMW exit reuses the RUN decode so
  // a hazard arriving in the release cycle is not dropped.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    run_dec   = 1'b0;
    st_f = 1'b0; st_d = 1'b0; st_e = 1'b0; st_m = 1'b0; st_w = 1'b0;
    fl_d = 1'b0; fl_e = 1'b0; fl_m = 1'b0; fl_w = 1'b0;
    redirect  = 1'b0;
    timeout   = 1'b0;

    case (state)
      RUN: run_dec = 1'b1;

      MEMW: begin
        if (sram_stall) begin
          {st_f, st_d, st_e, st_m, st_w} = 5'b11111;
        end else begin
          run_dec = 1'b1;
        end
      end

      DIV: begin
        if (hz.i_exc) begin
          {fl_d, fl_e, fl_m, fl_w} = 4'b1111;
          redirect  = 1'b1;
          state_nxt = RUN;
          cnt_nxt   = '0;
        end else if (sram_stall) begin
          {st_f, st_d, st_e, st_m, st_w} = 5'b11111;
        end else if (hz.i_div_ready) begin
          state_nxt = RUN;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          timeout   = 1'b1;
          state_nxt = RUN;
          cnt_nxt   = '0;
        end else begin
          {st_f, st_d, st_e} = 3'b111;
          fl_m    = 1'b1;
          cnt_nxt = cnt + CNT_W'(1);
        end
      end

      EXCP: begin
        if (hz.i_data_stall) begin
          {st_f, st_d, st_e, st_m, st_w} = 5'b11111;
        end else begin
          {fl_d, fl_e, fl_m, fl_w} = 4'b1111;
          redirect  = 1'b1;
          state_nxt = RUN;
        end
      end

      default: state_nxt = RUN;
    endcase

    if (run_dec) begin
      state_nxt = RUN;
      if (hz.i_exc && !hz.i_data_stall) begin
        {fl_d, fl_e, fl_m, fl_w} = 4'b1111;
        redirect = 1'b1;
      end else if (hz.i_exc) begin
        {st_f, st_d, st_e, st_m, st_w} = 5'b11111;
        state_nxt = EXCP;
      end else if (sram_stall) begin
        {st_f, st_d, st_e, st_m, st_w} = 5'b11111;
        state_nxt = MEMW;
      end else if (hz.i_div_start) begin
        {st_f, st_d, st_e} = 3'b111;
        fl_m      = 1'b1;
        cnt_nxt   = '0;
        state_nxt = DIV;
      end else if (hz.i_ld_use) begin
        {st_f, st_d} = 2'b11;
        fl_e = 1'b1;
      end else if (hz.i_br_taken) begin
        fl_d = 1'b1;
      end
    end
  end

  // Output gating: nothing asserts in reset, and a flushed stage is never also held.
  always_comb begin
    hz.o_stall_f      = ~rst & st_f;
    hz.o_stall_d      = ~rst & st_d & ~fl_d;
    hz.o_stall_e      = ~rst & st_e & ~fl_e;
    hz.o_stall_m      = ~rst & st_m & ~fl_m;
    hz.o_stall_w      = ~rst & st_w & ~fl_w;
    hz.o_flush_d      = ~rst & fl_d;
    hz.o_flush_e      = ~rst & fl_e;
    hz.o_flush_m      = ~rst & fl_m;
    hz.o_flush_w      = ~rst & fl_w;
    hz.o_exc_redirect = ~rst & redirect;
    hz.o_div_timeout  = ~rst & timeout;
    hz.o_state        = rst ? 2'd0 : state;
  end

`ifdef PIPE_HAZARD_CTRL_PERF_EN
  logic [31:0] perf_cnt;

  // Saturating count of cycles in which the D stage is held.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_cnt <= '0;
    end else if (hz.o_stall_d && (perf_cnt != 32'hFFFF_FFFF)) begin
      perf_cnt <= perf_cnt + 32'd1;
    end
  end

  assign hz.o_stall_cnt = rst ? 32'd0 : perf_cnt;
`else
  assign hz.o_stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with an episode-level reference model.
module tb_pipe_hazard_ctrl;

  localparam int DIV_MAX = 36;

  // stimulus bits {rst, ld, br, div_start, div_ready, inst_stall, data_stall, exc}
  localparam logic [7:0] R  = 8'h80, LD = 8'h40, BR = 8'h20, DS = 8'h10,
                         DR = 8'h08, IS = 8'h04, DT = 8'h02, EX = 8'h01;

  // output pattern {stall f,d,e,m,w, flush d,e,m,w}
  localparam logic [8:0] NONE       = 9'b00000_0000;
  localparam logic [8:0] STALL_ALL  = 9'b11111_0000;
  localparam logic [8:0] FLUSH_DEWM = 9'b00000_1111;
  localparam logic [8:0] DIV_HOLD   = 9'b11100_0010;
  localparam logic [8:0] LD_USE     = 9'b11000_0100;
  localparam logic [8:0] BR_FLUSH   = 9'b00000_1000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  bit   running = 1'b1;

  pipe_hazard_ctrl_if bus ();

  pipe_hazard_ctrl #(.DIV_MAX_CYC(DIV_MAX), .CNT_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (bus.slave)
  );

  always #5 clk = ~clk;

  wire [8:0] out_vec = {bus.o_stall_f, bus.o_stall_d, bus.o_stall_e, bus.o_stall_m,
                        bus.o_stall_w, bus.o_flush_d, bus.o_flush_e, bus.o_flush_m,
                        bus.o_flush_w};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Reference model: which episode the pipe is in and how far a divide has run.
  int          m_mode   = 0;   // 0 RUN, 1 DIV, 2 MEMW, 3 EXCP
  int          m_div_n  = 0;   // DIV cycles completed so far
  logic [31:0] m_perf   = 0;
  logic [8:0]  e_vec;
  logic        e_redir, e_tout;
  int          e_state, n_mode;
  bit          sram, decode;

  always @(negedge clk) begin
    if (running) begin
      e_vec = NONE; e_redir = 1'b0; e_tout = 1'b0;
      e_state = rst ? 0 : m_mode;
      n_mode = m_mode;
      sram = bus.i_inst_stall | bus.i_data_stall;
      decode = (m_mode == 0) || (m_mode == 2 && !sram);
      if (rst) begin
        n_mode = 0; m_div_n = 0;
      end else if (decode) begin
        n_mode = 0;
        if (bus.i_exc && !bus.i_data_stall) begin e_vec = FLUSH_DEWM; e_redir = 1'b1; end
        else if (bus.i_exc)       begin e_vec = STALL_ALL; n_mode = 3; end
        else if (sram)            begin e_vec = STALL_ALL; n_mode = 2; end
        else if (bus.i_div_start) begin e_vec = DIV_HOLD; n_mode = 1; m_div_n = 0; end
        else if (bus.i_ld_use)      e_vec = LD_USE;
        else if (bus.i_br_taken)    e_vec = BR_FLUSH;
      end else if (m_mode == 2) begin
        e_vec = STALL_ALL;
      end else if (m_mode == 1) begin
        if (bus.i_exc)                 begin e_vec = FLUSH_DEWM; e_redir = 1'b1; n_mode = 0; end
        else if (sram)                   e_vec = STALL_ALL;
        else if (bus.i_div_ready)        n_mode = 0;
        else if (m_div_n + 1 == DIV_MAX) begin e_tout = 1'b1; n_mode = 0; end
        else begin e_vec = DIV_HOLD; m_div_n++; end
      end else begin
        if (bus.i_data_stall) e_vec = STALL_ALL;
        else begin e_vec = FLUSH_DEWM; e_redir = 1'b1; n_mode = 0; end
      end

      check("outputs", {53'd0, out_vec, bus.o_exc_redirect, bus.o_div_timeout},
            {53'd0, e_vec, e_redir, e_tout});
      check("state", {62'd0, bus.o_state}, 64'(e_state));
      check("stall_cnt", {32'd0, bus.o_stall_cnt}, {32'd0, m_perf});

      m_mode = n_mode;
      if (rst) m_perf = 0;
`ifdef PIPE_HAZARD_CTRL_PERF_EN
      else if (e_vec[7] && m_perf != 32'hFFFF_FFFF) m_perf = m_perf + 1;
`endif
    end
  end

  task automatic apply(input logic [7:0] v);
    rst              = v[7];
    bus.i_ld_use     = v[6];
    bus.i_br_taken   = v[5];
    bus.i_div_start  = v[4];
    bus.i_div_ready  = v[3];
    bus.i_inst_stall = v[2];
    bus.i_data_stall = v[1];
    bus.i_exc        = v[0];
  endtask

  task automatic drive(input logic [7:0] v);
    apply(v);
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  // exp = {pattern, redirect, timeout}
  task automatic drive_lit(input logic [7:0] v, input string name,
                           input logic [10:0] exp, input logic [1:0] st);
    apply(v);
    @(negedge clk);
    check(name, {53'd0, out_vec, bus.o_exc_redirect, bus.o_div_timeout}, {53'd0, exp});
    check({name, "_state"}, {62'd0, bus.o_state}, {62'd0, st});
    @(posedge clk);
    #1;
  endtask

  initial begin
    apply(R);
    drive_lit(R, "reset0", {NONE, 2'b00}, 2'd0);
    drive_lit(R, "reset1", {NONE, 2'b00}, 2'd0);

    // load-use and branch
    drive_lit(LD, "ld_use", {LD_USE, 2'b00}, 2'd0);
    drive_lit(BR, "br_taken", {BR_FLUSH, 2'b00}, 2'd0);
    drive_lit(LD | BR, "ld_over_br", {LD_USE, 2'b00}, 2'd0);
    drive(8'h00);

    // divide released by ready on DIV cycle 5
    drive_lit(DS, "div_start", {DIV_HOLD, 2'b00}, 2'd0);
    repeat (4) drive(8'h00);
    drive_lit(DR, "div_ready", {NONE, 2'b00}, 2'd1);
    drive_lit(8'h00, "after_div", {NONE, 2'b00}, 2'd0);

    // divide watchdog
    drive(DS);
    repeat (35) drive(8'h00);
    drive_lit(8'h00, "div_timeout", {NONE, 2'b01}, 2'd1);
    drive_lit(8'h00, "after_timeout", {NONE, 2'b00}, 2'd0);

    // SRAM stall freezes the watchdog
    drive(DS);
    repeat (34) drive(8'h00);
    repeat (3) drive(DT);
    drive_lit(8'h00, "div_frozen_35", {DIV_HOLD, 2'b00}, 2'd1);
    drive_lit(8'h00, "div_frozen_to", {NONE, 2'b01}, 2'd1);

    // exception aborts divide, even with data stall
    drive(DS);
    drive(8'h00);
    drive_lit(EX | DT, "div_exc_abort", {FLUSH_DEWM, 2'b10}, 2'd1);
    drive_lit(8'h00, "after_abort", {NONE, 2'b00}, 2'd0);

    // data stall with load-use held
    drive_lit(DT | LD, "memw_1", {STALL_ALL, 2'b00}, 2'd0);
    drive_lit(DT | LD, "memw_2", {STALL_ALL, 2'b00}, 2'd2);
    drive_lit(DT | LD, "memw_3", {STALL_ALL, 2'b00}, 2'd2);
    drive_lit(LD, "memw_exit_ld", {LD_USE, 2'b00}, 2'd2);
    drive_lit(8'h00, "after_memw", {NONE, 2'b00}, 2'd0);

    // exception during data stall
    drive_lit(EX | DT, "excp_1", {STALL_ALL, 2'b00}, 2'd0);
    drive_lit(EX | DT, "excp_2", {STALL_ALL, 2'b00}, 2'd3);
    drive_lit(8'h00, "excp_redirect", {FLUSH_DEWM, 2'b10}, 2'd3);
    drive_lit(8'h00, "after_excp", {NONE, 2'b00}, 2'd0);

    // MEMW exits into exception and into divide
    drive(IS);
    drive_lit(EX | BR, "memw_exit_exc", {FLUSH_DEWM, 2'b10}, 2'd2);
    drive(IS);
    drive_lit(DS, "memw_exit_div", {DIV_HOLD, 2'b00}, 2'd2);
    drive(DR);

    // RUN priority
    drive_lit(EX | LD | BR | DS, "exc_first", {FLUSH_DEWM, 2'b10}, 2'd0);
    drive_lit(EX | IS, "exc_inst_stall", {FLUSH_DEWM, 2'b10}, 2'd0);
    drive_lit(DS | LD | BR, "div_over_ld", {DIV_HOLD, 2'b00}, 2'd0);
    drive(DR);

    // reset in the middle of a divide
    drive(DS);
    repeat (3) drive(8'h00);
    drive_lit(R, "rst_mid_div", {NONE, 2'b00}, 2'd0);
    drive_lit(8'h00, "post_rst", {NONE, 2'b00}, 2'd0);
    drive_lit(LD, "post_rst_ld", {LD_USE, 2'b00}, 2'd0);
    drive(8'h00);

    running = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
